// File: rtl/reg_dump_rx.sv
// reg_dump_rx: receives a serial register-dump frame (N_WORDS words of WORD_W
// bits, LSB first, contiguous) into a word buffer with registered read-back.
// Optional build macro DUMP_RX_PARITY_EN appends one even-parity bit per word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start pulse
// SHIFT | receiving frame bits; start here aborts and restarts the frame
// DONE  | one-cycle frame_done pulse; start here begins the next frame
module reg_dump_rx #(
    parameter int N_WORDS = 8,
    parameter int WORD_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              start,
    input  logic [4:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              err
);

`ifdef DUMP_RX_PARITY_EN
    localparam int BITS_PER_WORD = WORD_W + 1;
`else
    localparam int BITS_PER_WORD = WORD_W;
`endif
    localparam int WC_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BC_W = $clog2(BITS_PER_WORD);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(BITS_PER_WORD - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [BC_W-1:0]     bit_cnt;
    logic [WC_W-1:0]     word_cnt;
    logic [WORD_W-1:0]   shift_reg;
    logic [WORD_W-1:0]   shift_nxt;
    logic [WORD_W-1:0]   mem [N_WORDS];
    logic [WORD_W-1:0]   rd_nxt;
    logic                wr_en;
    logic                word_end;
    logic                abort;

    // Incoming bit enters at the MSB so the first bit ends up at the LSB.
    assign shift_nxt = {serial_in, shift_reg[WORD_W-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        wr_en      = 1'b0;
        word_end   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (start) begin
                    abort = 1'b1;
                end else begin
                    wr_en    = (bit_cnt == LAST_DATA);
                    word_end = (bit_cnt == LAST_BIT);
                    if (word_end && (word_cnt == LAST_WORD)) state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit/word counters, shift register, status flags and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // A start pulse restarts reception from any state.
            if (start) begin
                shift_reg <= shift_nxt;
                bit_cnt   <= BC_W'(1);
                word_cnt  <= '0;
            end else if (state == SHIFT) begin
                // Shifting during the parity slot is harmless: the word was
                // already stored and the next word overwrites every bit.
                shift_reg <= shift_nxt;
                if (word_end) begin
                    bit_cnt  <= '0;
                    word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (abort) err <= 1'b1;
`ifdef DUMP_RX_PARITY_EN
            // Even parity: stored word plus parity bit must have even weight.
            if ((state == SHIFT) && !start && (bit_cnt == LAST_BIT) &&
                ((^shift_reg) ^ serial_in))
                err <= 1'b1;
`endif
            if (frame_done) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Read mux; out-of-range addresses return zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (rd_addr == 5'(i)) rd_nxt = mem[i];
        end
    end

    // Word buffer write and registered read (read sees pre-write contents).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= rd_nxt;
            for (int i = 0; i < N_WORDS; i++) begin
                if (wr_en && (word_cnt == WC_W'(i))) mem[i] <= shift_nxt;
            end
        end
    end

endmodule

// File: doc/reg_dump_rx.md
REG_DUMP_RX -- requirements
Module: reg_dump_rx

Interface
REQ-001 SHALL have parameter N_WORDS, default 8, words per dump frame (2..32).
REQ-002 SHALL have parameter WORD_W, default 16, bits per word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port serial_in  input  1  dump data bit, sampled every clk.
REQ-006 SHALL have port start  input  1  one-cycle pulse coincident with bit 0 of word 0.
REQ-007 SHALL have port rd_addr  input  5  buffer word index for parallel read-back.
REQ-008 SHALL have port rd_data  output  WORD_W  registered buffer contents at rd_addr.
REQ-009 SHALL have port busy  output  1  high while a frame is being received.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a full frame is stored.
REQ-011 SHALL have port frame_cnt  output  8  count of completed frames.
REQ-012 SHALL have port err  output  1  sticky error flag (abort or parity).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 -> capture serial_in as bit 0, bit_cnt=1, word_cnt=0, go SHIFT; start=0 -> stay.
REQ-015 SHIFT: shift serial_in into word register LSB-first each cycle, bit_cnt increments.
REQ-016 On WORD_W-th bit, SHALL write the assembled word to buffer[word_cnt] on the next edge, bit_cnt wraps to 0, word_cnt increments.
REQ-017 Frame is contiguous: bit 0 of word k+1 SHALL be sampled the cycle after the last bit of word k (no gap).
REQ-018 After last bit of word N_WORDS-1 SHALL go DONE; DONE lasts one cycle, asserts frame_done, frame_cnt+1, then IDLE.
REQ-019 frame_done latency SHALL be exactly 1 cycle after the final bit is sampled.
REQ-020 start during SHIFT SHALL abort the current frame, set err, and restart reception with that cycle's bit as bit 0 of word 0.
REQ-021 start during DONE SHALL be honoured: frame_done still pulses, reception restarts as from IDLE.
REQ-022 Words of an aborted frame already written SHALL remain in the buffer; frame_cnt SHALL NOT increment.
REQ-023 frame_cnt SHALL wrap 255 -> 0.
REQ-024 busy SHALL be high in SHIFT only.
REQ-025 rd_data SHALL reflect buffer[rd_addr] one cycle after rd_addr is applied; rd_addr >= N_WORDS returns 0.
REQ-026 Read and a same-cycle write to the same address SHALL return the old value.
REQ-027 err SHALL clear only on reset.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, bit_cnt=0, word_cnt=0, busy=0, frame_done=0, frame_cnt=0, err=0, rd_data=0.
REQ-029 Buffer contents SHALL be cleared to 0 by reset.
REQ-030 Reset mid-frame SHALL discard the partial word; no frame_done after release.

Configuration
REQ-031 With DUMP_RX_PARITY_EN defined, each word SHALL be followed by one even-parity bit (frame length N_WORDS*(WORD_W+1)); a mismatch sets err, word still stored.
REQ-032 Without DUMP_RX_PARITY_EN, no parity bit exists; frame length N_WORDS*WORD_W; err set only by abort.

Verification (N_WORDS=4, WORD_W=16, parity off unless stated)
REQ-033 Send words 0x0001,0xABCD,0x8000,0xFFFF after start -> frame_done exactly 1 cycle after bit 63, reads 0..3 return those values, frame_cnt=1, err=0.
REQ-034 Reassert start at bit 20 of a frame, then send a full frame 0x1111..0x4444 -> err=1, frame_cnt=1, buffer = 0x1111,0x2222,0x3333,0x4444.
REQ-035 Pull rst_n low at bit 30, release, idle 10 cycles -> busy=0, no frame_done, buffer all 0, frame_cnt=0.
REQ-036 Send 256 back-to-back frames -> frame_cnt=0, frame_done pulsed 256 times, start in DONE cycle accepted.
REQ-037 Read rd_addr=5 -> rd_data=0; read addr 2 while it is written -> old value that cycle, new value next.
REQ-038 DUMP_RX_PARITY_EN: word 0x0003 with parity 1 -> err=1, buffer[0]=0x0003; correct parity 0 -> err stays 0.
